// File: rtl/lut_sched_pkg.sv
// Shared types, defaults and width helpers for the time-multiplexed LUT layer scheduler.
package lut_sched_pkg;

    localparam int DEF_NUM_FEAT    = 32;
    localparam int DEF_BW          = 2;
    localparam int DEF_FANIN       = 4;
    localparam int DEF_NUM_NEURONS = 8;

    localparam logic CFG_SEL_TT  = 1'b0;
    localparam logic CFG_SEL_IDX = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT
    } state_t;

    // Keeps derived index widths at least one bit wide for degenerate sizes.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// Shared truth-table store: one write port, one registered read port, address {neuron, addr}.
module lut_neuron_ram
    import lut_sched_pkg::*;
#(
    parameter  int BW          = DEF_BW,
    parameter  int ADDR_W      = DEF_FANIN * DEF_BW,
    parameter  int NUM_NEURONS = DEF_NUM_NEURONS,
    localparam int NEUR_W      = clog2_min1(NUM_NEURONS),
    localparam int A_W         = NEUR_W + ADDR_W,
    localparam int DEPTH       = NUM_NEURONS << ADDR_W
) (
    input  logic           clk,
    input  logic           we_i,
    input  logic [A_W-1:0] waddr_i,
    input  logic [BW-1:0]  wdata_i,
    input  logic           re_i,
    input  logic [A_W-1:0] raddr_i,
    output logic [BW-1:0]  rdata_o
);

    (* ram_style = "distributed" *) logic [BW-1:0] mem_q [DEPTH];
    logic [BW-1:0] rdata_q;

    // NOTE: storage arrays carry no reset; their contents are loaded at run time
    // and must survive rst, and a reset would also block RAM inference.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lut_layer_scheduler.sv
// Evaluates one LogicNets LUT layer by walking all neurons through a single shared truth-table RAM.
module lut_layer_scheduler
    import lut_sched_pkg::*;
#(
    parameter  int NUM_FEAT    = DEF_NUM_FEAT,
    parameter  int BW          = DEF_BW,
    parameter  int FANIN       = DEF_FANIN,
    parameter  int NUM_NEURONS = DEF_NUM_NEURONS,
    localparam int ADDR_W      = FANIN * BW,
    localparam int FEAT_W      = clog2_min1(NUM_FEAT),
    localparam int NEUR_W      = clog2_min1(NUM_NEURONS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic                      cfg_sel,
    input  logic [NEUR_W-1:0]         cfg_neuron,
    input  logic [ADDR_W-1:0]         cfg_addr,
    input  logic [FEAT_W-1:0]         cfg_data,
    output logic                      cfg_err,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [NUM_FEAT*BW-1:0]    s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [NUM_NEURONS*BW-1:0] m_data,
    output logic                      busy
);

    localparam int SLOT_W    = clog2_min1(FANIN);
    localparam int FEAT_SPAN = 1 << FEAT_W;

    state_t            state_q, state_d;
    logic [NEUR_W-1:0] cnt_q, cnt_d;

    logic [BW-1:0]     feat_q   [NUM_FEAT];
    logic [BW-1:0]     feat_pad [FEAT_SPAN];
    logic [FEAT_W-1:0] idx_q    [NUM_NEURONS][FANIN];
    logic [BW-1:0]     out_q    [NUM_NEURONS];

    logic              wr_en_q;
    logic [NEUR_W-1:0] wr_idx_q;
    logic              cfg_err_q;

    logic              accept;
    logic              cfg_ok;
    logic              tt_we;
    logic              idx_we;
    logic [ADDR_W-1:0] rd_addr;
    logic [BW-1:0]     rd_data;

    // s_ready depends only on registered state (and reset), never on m_ready.
    assign s_ready = (state_q == IDLE) && !rst;
    assign m_valid = (state_q == OUT);
    assign busy    = (state_q != IDLE);
    assign cfg_err = cfg_err_q;

    assign accept = s_valid && s_ready;
    assign cfg_ok = cfg_we && (state_q == IDLE) && !s_valid;
    assign tt_we  = cfg_ok && (cfg_sel == CFG_SEL_TT);
    assign idx_we = cfg_ok && (cfg_sel == CFG_SEL_IDX);

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = cnt_q + NEUR_W'(1);
                if (cnt_q == NEUR_W'(NUM_NEURONS - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: state_d = OUT;
            OUT: begin
                if (m_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read results trail their issue by one cycle; DRAIN exists to land the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_idx_q  <= '0;
            cfg_err_q <= 1'b0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                out_q[n] <= '0;
            end
        end else begin
            wr_en_q   <= (state_q == RUN);
            wr_idx_q  <= cnt_q;
            cfg_err_q <= cfg_we && !cfg_ok;
            if (wr_en_q) begin
                out_q[wr_idx_q] <= rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int f = 0; f < NUM_FEAT; f++) begin
                feat_q[f] <= s_data[f*BW +: BW];
            end
        end
        if (idx_we) begin
            idx_q[cfg_neuron][cfg_addr[SLOT_W-1:0]] <= cfg_data;
        end
    end

    // Index codes beyond the feature count alias to feature 0, resolved at elaboration.
    for (genvar f = 0; f < FEAT_SPAN; f++) begin : g_pad
        if (f < NUM_FEAT) begin : g_real
            assign feat_pad[f] = feat_q[f];
        end else begin : g_alias
            assign feat_pad[f] = feat_q[0];
        end
    end

    always_comb begin
        rd_addr = '0;
        for (int k = 0; k < FANIN; k++) begin
            rd_addr[k*BW +: BW] = feat_pad[idx_q[cnt_q][k]];
        end
    end

    lut_neuron_ram #(
        .BW          (BW),
        .ADDR_W      (ADDR_W),
        .NUM_NEURONS (NUM_NEURONS)
    ) u_ram (
        .clk     (clk),
        .we_i    (tt_we),
        .waddr_i ({cfg_neuron, cfg_addr}),
        .wdata_i (cfg_data[BW-1:0]),
        .re_i    (state_q == RUN),
        .raddr_i ({cnt_q, rd_addr}),
        .rdata_o (rd_data)
    );

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_pack
        assign m_data[n*BW +: BW] = out_q[n];
    end

endmodule
